alu_status_register: RTL and testbench
======================================

ALU_STATUS_REGISTER -- requirements
Module: alu_status_register

Interface
REQ-001 Parameter: CNT_WIDTH, default 8, width of the saturating overflow event counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flag_valid  input  1  the flag inputs and ALUControl are valid this cycle.
REQ-005 set_flags  input  1  the instruction writes the status register; ignored when flag_valid=0.
REQ-006 ALUControl  input  4  ALU operation code: 4'b1000 add, 4'b1001 subtract, all other codes non-arithmetic.
REQ-007 n_in, z_in, c_in, v_in  input  1 each  negative, zero, carry and overflow flags from the ALU flag units.
REQ-008 clr_sticky  input  1  clears v_sticky and ovf_count.
REQ-009 cond  input  4  condition code evaluated against the registered flags.
REQ-010 n, z, c, v  output  1 each  registered status flags.
REQ-011 v_sticky  output  1  set by any committed overflow; held until cleared.
REQ-012 ovf_count  output  CNT_WIDTH  saturating count of committed overflows.
REQ-013 upd_valid  output  1  one-cycle pulse; the flags changed on the previous edge.
REQ-014 cond_pass  output  1  result of cond against n/z/c/v; combinational from registered state only.

Function
REQ-015 Commit: edge where flag_valid=1 and set_flags=1; no other edge changes n/z/c/v.
REQ-016 Arithmetic commit (ALUControl 1000 or 1001): n, z, c, v <= n_in, z_in, c_in, v_in.
REQ-017 Non-arithmetic commit: n, z <= n_in, z_in; c and v hold their previous values; v_in and c_in are ignored.
REQ-018 Latency: committed flags visible on outputs 1 cycle after the commit edge; no bypass from inputs to n/z/c/v/cond_pass.
REQ-019 upd_valid = 1 exactly in the cycle after a commit edge, else 0; back-to-back commits give a continuous high.
REQ-020 Overflow event: arithmetic commit with v_in=1.
REQ-021 On an overflow event, v_sticky <= 1 and ovf_count <= ovf_count+1, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-022 clr_sticky=1 with no overflow event: v_sticky <= 0, ovf_count <= 0.
REQ-023 clr_sticky=1 with a simultaneous overflow event: the event wins, v_sticky <= 1 and ovf_count <= 1.
REQ-024 clr_sticky has no effect on n/z/c/v or upd_valid.
REQ-025 cond encoding: 0000 EQ (z), 0001 NE (!z), 0010 CS (c), 0011 CC (!c), 0100 MI (n), 0101 PL (!n), 0110 VS (v), 0111 VC (!v), 1000 HI (c & !z), 1001 LS (!c | z), 1010 GE (n==v), 1011 LT (n!=v), 1100 GT (!z & n==v), 1101 LE (z | n!=v), 1110 AL (1), 1111 NV (0).
REQ-026 Update FSM states: IDLE and UPDATED. Any state goes to UPDATED on a commit edge and to IDLE otherwise; upd_valid=1 only in UPDATED.
REQ-027 X or unknown ALUControl is treated as non-arithmetic; there is no error output.

Reset
REQ-028 rst=1 at an edge forces n=z=c=v=0, v_sticky=0, ovf_count=0, FSM=IDLE, upd_valid=0; rst overrides commit and clr_sticky on that edge.
REQ-029 Reset mid-stream discards any commit presented on the reset edge; the first commit after rst deasserts behaves normally.
REQ-030 After reset, cond_pass = 1 for EQ? no: z=0, so EQ=0, NE=1, GE=1, AL=1, NV=0.

Verification
REQ-031 Add overflow: ALUControl=1000, n_in=0, z_in=0, c_in=1, v_in=1, commit -> next cycle c=1, v=1, v_sticky=1, ovf_count=1, upd_valid=1, cond=0110 gives cond_pass=1.
REQ-032 Logic op preserves C/V: after REQ-031, commit ALUControl=0000 with n_in=1, z_in=0, c_in=0, v_in=0 -> n=1, c=1, v=1, ovf_count stays 1; cond=1011 (LT) gives cond_pass=0.
REQ-033 No-write: flag_valid=1, set_flags=0, v_in=1, ALUControl=1001 -> flags, v_sticky, ovf_count unchanged; upd_valid=0.
REQ-034 Saturation: CNT_WIDTH=2, 5 consecutive subtract commits with v_in=1 -> ovf_count 1,2,3,3,3; upd_valid held high across the run.
REQ-035 Clear collision: ovf_count=3, clr_sticky=1 on the same edge as an overflow event -> v_sticky=1, ovf_count=1; clr_sticky alone on the next edge -> v_sticky=0, ovf_count=0.
REQ-036 Reset priority: rst=1 on the same edge as an overflow commit with flags nonzero -> all outputs 0 next cycle; cond=0001 gives cond_pass=1.

Source files
------------

// File: rtl/alu_status_register.sv
// ALU status register: holds the N/Z/C/V condition flags written by the ALU,
// keeps a sticky overflow bit with a saturating overflow event counter, pulses
// upd_valid the cycle after the flags change, and evaluates a condition code
// against the registered flags.
module alu_status_register #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag_valid,
    input  logic                 set_flags,
    input  logic [3:0]           ALUControl,
    input  logic                 n_in,
    input  logic                 z_in,
    input  logic                 c_in,
    input  logic                 v_in,
    input  logic                 clr_sticky,
    input  logic [3:0]           cond,
    output logic                 n,
    output logic                 z,
    output logic                 c,
    output logic                 v,
    output logic                 v_sticky,
    output logic [CNT_WIDTH-1:0] ovf_count,
    output logic                 upd_valid,
    output logic                 cond_pass
);

    typedef enum logic {
        IDLE,
        UPDATED
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state;
    logic   commit;
    logic   is_arith;
    logic   ovf_event;

    // Decode the commit strobe and whether this op is an add/subtract.
    always_comb begin
        // NOTE: default first so every path assigns is_arith; no latch is inferred.
        is_arith = 1'b0;
        // An unknown opcode matches no item and falls to the non-arithmetic default.
        case (ALUControl)
            4'b1000: is_arith = 1'b1;
            4'b1001: is_arith = 1'b1;
            default: is_arith = 1'b0;
        endcase
        commit    = flag_valid & set_flags;
        ovf_event = commit & is_arith & v_in;
    end

    // Flag register: arithmetic ops write all four flags, others only N and Z.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            n <= 1'b0;
            z <= 1'b0;
            c <= 1'b0;
            v <= 1'b0;
        end else if (commit) begin
            n <= n_in;
            z <= z_in;
            if (is_arith) begin
                c <= c_in;
                v <= v_in;
            end
        end
    end

    // Sticky overflow and saturating counter; a new overflow beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_sticky  <= 1'b0;
            ovf_count <= '0;
        end else if (ovf_event) begin
            v_sticky <= 1'b1;
            if (clr_sticky) begin
                ovf_count <= CNT_ONE;
            end else if (ovf_count != CNT_MAX) begin
                ovf_count <= ovf_count + CNT_ONE;
            end
        end else if (clr_sticky) begin
            v_sticky  <= 1'b0;
            ovf_count <= '0;
        end
    end

    // Update FSM: UPDATED for the cycle following each commit, IDLE otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            upd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit) begin
                        state     <= UPDATED;
                        upd_valid <= 1'b1;
                    end
                end
                UPDATED: begin
                    if (!commit) begin
                        state     <= IDLE;
                        upd_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    upd_valid <= 1'b0;
                end
            endcase
        end
    end

    // Condition evaluation from registered flags only; no input bypass.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_status_register.sv
// Directed bench for alu_status_register with hand-computed expectations.
// The counter is built 2 bits wide so saturation is reached quickly.
module tb_alu_status_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_valid;
    logic       set_flags;
    logic [3:0] ALUControl;
    logic       n_in, z_in, c_in, v_in;
    logic       clr_sticky;
    logic [3:0] cond;
    logic       n, z, c, v;
    logic       v_sticky;
    logic [1:0] ovf_count;
    logic       upd_valid;
    logic       cond_pass;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_AND = 4'b0000;

    alu_status_register #(.CNT_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flag_valid (flag_valid),
        .set_flags  (set_flags),
        .ALUControl (ALUControl),
        .n_in       (n_in),
        .z_in       (z_in),
        .c_in       (c_in),
        .v_in       (v_in),
        .clr_sticky (clr_sticky),
        .cond       (cond),
        .n          (n),
        .z          (z),
        .c          (c),
        .v          (v),
        .v_sticky   (v_sticky),
        .ovf_count  (ovf_count),
        .upd_valid  (upd_valid),
        .cond_pass  (cond_pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one cycle of inputs at the falling edge, then settle just past the rising edge.
    task automatic step(input logic r, input logic fv, input logic sf, input logic [3:0] op,
                        input logic ni, input logic zi, input logic ci, input logic vi,
                        input logic clr);
        @(negedge clk);
        rst        = r;
        flag_valid = fv;
        set_flags  = sf;
        ALUControl = op;
        n_in       = ni;
        z_in       = zi;
        c_in       = ci;
        v_in       = vi;
        clr_sticky = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] nzcv, input logic vs,
                               input logic [1:0] cnt, input logic upd);
        check({tag, ".nzcv"}, {28'd0, n, z, c, v}, {28'd0, nzcv});
        check({tag, ".v_sticky"}, {31'd0, v_sticky}, {31'd0, vs});
        check({tag, ".ovf_count"}, {30'd0, ovf_count}, {30'd0, cnt});
        check({tag, ".upd_valid"}, {31'd0, upd_valid}, {31'd0, upd});
    endtask

    task automatic check_cond(input string tag, input logic [3:0] cc, input logic exp);
        cond = cc;
        #1;
        check(tag, {31'd0, cond_pass}, {31'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flag_valid = 1'b0; set_flags = 1'b0; ALUControl = OP_AND;
        n_in = 1'b0; z_in = 1'b0; c_in = 1'b0; v_in = 1'b0; clr_sticky = 1'b0; cond = 4'b0000;

        // Reset state and condition results on all-zero flags.
        step(1, 0, 0, OP_AND, 0, 0, 0, 0, 0);
        step(1, 0, 0, OP_AND, 0, 0, 0, 0, 0);
        check_flags("reset", 4'b0000, 0, 2'd0, 0);
        check_cond("reset.EQ", 4'b0000, 0);
        check_cond("reset.NE", 4'b0001, 1);
        check_cond("reset.GE", 4'b1010, 1);
        check_cond("reset.AL", 4'b1110, 1);
        check_cond("reset.NV", 4'b1111, 0);

        // Add with carry and overflow.
        step(0, 1, 1, OP_ADD, 0, 0, 1, 1, 0);
        check_flags("add_ovf", 4'b0011, 1, 2'd1, 1);
        check_cond("add_ovf.VS", 4'b0110, 1);

        // Logic op writes N/Z only; C and V hold.
        step(0, 1, 1, OP_AND, 1, 0, 0, 0, 0);
        check_flags("logic_op", 4'b1011, 1, 2'd1, 1);
        check_cond("logic_op.LT", 4'b1011, 0);
        check_cond("logic_op.GE", 4'b1010, 1);

        // set_flags low: nothing written even with overflow on the inputs.
        step(0, 1, 0, OP_SUB, 0, 1, 0, 1, 0);
        check_flags("no_write", 4'b1011, 1, 2'd1, 0);

        // flag_valid low: set_flags ignored.
        step(0, 0, 1, OP_SUB, 0, 1, 0, 1, 0);
        check_flags("not_valid", 4'b1011, 1, 2'd1, 0);

        // Unknown opcode behaves as non-arithmetic: C/V hold, no overflow counted.
        step(0, 1, 1, 4'bxxxx, 0, 1, 0, 1, 0);
        check_flags("x_op", 4'b0111, 1, 2'd1, 1);
        check_cond("x_op.EQ", 4'b0000, 1);
        check_cond("x_op.HI", 4'b1000, 0);
        check_cond("x_op.LS", 4'b1001, 1);

        // Clear alone: sticky and counter drop, flags untouched.
        step(0, 0, 0, OP_AND, 0, 0, 0, 0, 1);
        check_flags("clear", 4'b0111, 0, 2'd0, 0);

        // Saturation: five overflowing subtracts -> 1,2,3,3,3 with upd_valid held.
        step(0, 1, 1, OP_SUB, 0, 0, 0, 1, 0);
        check_flags("sat1", 4'b0001, 1, 2'd1, 1);
        step(0, 1, 1, OP_SUB, 0, 0, 0, 1, 0);
        check_flags("sat2", 4'b0001, 1, 2'd2, 1);
        step(0, 1, 1, OP_SUB, 0, 0, 0, 1, 0);
        check_flags("sat3", 4'b0001, 1, 2'd3, 1);
        step(0, 1, 1, OP_SUB, 0, 0, 0, 1, 0);
        check_flags("sat4", 4'b0001, 1, 2'd3, 1);
        step(0, 1, 1, OP_SUB, 0, 0, 0, 1, 0);
        check_flags("sat5", 4'b0001, 1, 2'd3, 1);

        // Clear colliding with an overflow event: the event wins, count restarts at 1.
        step(0, 1, 1, OP_SUB, 0, 0, 0, 1, 1);
        check_flags("collide", 4'b0001, 1, 2'd1, 1);
        step(0, 0, 0, OP_AND, 0, 0, 0, 0, 1);
        check_flags("clear2", 4'b0001, 0, 2'd0, 0);

        // Arithmetic commit without overflow rewrites C/V.
        step(0, 1, 1, OP_ADD, 1, 0, 0, 0, 0);
        check_flags("add_noovf", 4'b1000, 0, 2'd0, 1);
        check_cond("add_noovf.GT", 4'b1100, 0);
        check_cond("add_noovf.LE", 4'b1101, 1);
        check_cond("add_noovf.MI", 4'b0100, 1);
        check_cond("add_noovf.CC", 4'b0011, 1);

        // Build nonzero state, then reset on the same edge as an overflow commit.
        step(0, 1, 1, OP_ADD, 1, 0, 1, 1, 0);
        check_flags("pre_rst", 4'b1011, 1, 2'd1, 1);
        step(1, 1, 1, OP_ADD, 1, 0, 1, 1, 1);
        check_flags("rst_prio", 4'b0000, 0, 2'd0, 0);
        check_cond("rst_prio.NE", 4'b0001, 1);

        // First commit after reset behaves normally.
        step(0, 1, 1, OP_ADD, 0, 1, 1, 0, 0);
        check_flags("post_rst", 4'b0110, 0, 2'd0, 1);
        check_cond("post_rst.EQ", 4'b0000, 1);

        // Idle cycle: upd_valid drops, flags hold.
        step(0, 0, 0, OP_AND, 0, 0, 0, 0, 0);
        check_flags("idle", 4'b0110, 0, 2'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
